// File: rtl/ysyx_22050854_axi_pkg.sv
// Shared AXI read-path types and constants:
// FSM encoding, burst type codes, default ARIDs.
package ysyx_22050854_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_R    = 2'd2
  } ar_state_e;

  localparam logic [1:0] INCR = 2'b01;

  localparam logic [3:0] ARID_IFU_DEF = 4'h0;
  localparam logic [3:0] ARID_LSU_DEF = 4'h1;

endpackage

// File: rtl/ysyx_22050854_rr_arb2.sv
// Two-way round-robin grant: req in, gnt index out.
// last_g updates only when the grant is taken.
module ysyx_22050854_rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt
);

  logic last_g;

  // Contended: favour whoever did not win last.
  always_comb begin
    gnt = req[1];
    if (req == 2'b11) gnt = ~last_g;
  end

  // Reset to 1 so the ICache wins the first contest.
  always_ff @(posedge clock) begin
    if (reset) last_g <= 1'b1;
    else if (take) last_g <= gnt;
  end

endmodule

// File: rtl/ysyx_22050854_axi_rd_arbiter.sv
// 2:1 AXI4 read arbiter (ICache=0, DCache=1) onto io_master AR/R.
// Whole-burst grants, registered AR, R beats steered to owner.
module ysyx_22050854_axi_rd_arbiter
  import ysyx_22050854_axi_pkg::*;
#(
  parameter logic [3:0] ARID_IFU = ARID_IFU_DEF,
  parameter logic [3:0] ARID_LSU = ARID_LSU_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  s_arvalid,
  output logic [1:0]  s_arready,
  input  logic [63:0] s_araddr,
  input  logic [15:0] s_arlen,
  input  logic [5:0]  s_arsize,
  input  logic [3:0]  s_arburst,
  output logic [1:0]  s_rvalid,
  input  logic [1:0]  s_rready,
  output logic [63:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rlast,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic [3:0]  m_arid,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [3:0]  m_rid,
  input  logic [63:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast
);

  ar_state_e state, state_n;
  logic      g, g_q, take;
  logic      unused_rid;

  assign unused_rid = ^m_rid;
  assign take = (state == ST_IDLE) && (|s_arvalid);

  ysyx_22050854_rr_arb2 u_arb (
    .clock (clock),
    .reset (reset),
    .req   (s_arvalid),
    .take  (take),
    .gnt   (g)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      g_q       <= 1'b0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      m_arburst <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        g_q       <= g;
        m_araddr  <= g ? s_araddr[63:32] : s_araddr[31:0];
        m_arlen   <= g ? s_arlen[15:8]   : s_arlen[7:0];
        m_arsize  <= g ? s_arsize[5:3]   : s_arsize[2:0];
        m_arburst <= g ? s_arburst[3:2]  : s_arburst[1:0];
      end
    end
  end

  always_comb begin
    state_n   = state;
    s_arready = '0;
    s_rvalid  = '0;
    m_rready  = 1'b0;
    m_arvalid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (|s_arvalid) begin
          s_arready[g] = 1'b1;
          state_n      = ST_ADDR;
        end
      end
      ST_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_n = ST_R;
      end
      ST_R: begin
        s_rvalid[g_q] = m_rvalid;
        m_rready      = s_rready[g_q];
        if (m_rvalid && s_rready[g_q] && m_rlast)
          state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign m_arid  = g_q ? ARID_LSU : ARID_IFU;
  assign s_rdata = m_rdata;
  assign s_rresp = m_rresp;
  assign s_rlast = m_rlast;

endmodule

// File: tb/tb_ysyx_22050854_axi_rd_arbiter.sv
// Directed bench for the 2:1 AXI read arbiter.
// R beats checked against a scoreboard queue.
module tb_ysyx_22050854_axi_rd_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  s_arvalid, s_arready;
  logic [63:0] s_araddr;
  logic [15:0] s_arlen;
  logic [5:0]  s_arsize;
  logic [3:0]  s_arburst;
  logic [1:0]  s_rvalid, s_rready;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        m_arvalid, m_arready;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic [3:0]  m_arid;
  logic        m_rvalid, m_rready;
  logic [3:0]  m_rid;
  logic [63:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        who;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t sb[$];

  always #5 clock = ~clock;

  ysyx_22050854_axi_rd_arbiter dut (
    .clock(clock), .reset(reset),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arid(m_arid),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Beats are consumed on the edge following this negedge.
  always @(negedge clock) begin
    if ((s_rvalid & s_rready) != 2'b00) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 1'b1, 1'b0);
      end else begin
        beat_t e;
        e = sb.pop_front();
        chk("beat_rvalid", s_rvalid, e.who ? 2'b10 : 2'b01);
        chk("beat_data", s_rdata, e.data);
        chk("beat_resp", s_rresp, e.resp);
        chk("beat_last", s_rlast, e.last);
        chk("beat_mrready", m_rready, 1'b1);
      end
    end
  end

  task automatic req(input int r, input logic [31:0] a,
                     input logic [7:0] len, input logic [2:0] sz);
    s_araddr[r*32 +: 32] = a;
    s_arlen[r*8 +: 8]    = len;
    s_arsize[r*3 +: 3]   = sz;
    s_arburst[r*2 +: 2]  = 2'b01;
    s_arvalid[r]         = 1'b1;
  endtask

  task automatic wait_accept(input int r, output int waited);
    logic found = 1'b0;
    waited = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      #1;
      chk("idle_arvalid", m_arvalid, 1'b0);
      if (s_arready != 2'b00) begin
        found = 1'b1;
        chk("accept_onehot", s_arready, 2'b01 << r);
        tick();
        s_arvalid[r] = 1'b0;
      end else begin
        waited++;
        tick();
      end
    end
    if (!found) chk("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic ar_phase(input int r, input logic [31:0] a,
                          input logic [7:0] len, input logic [2:0] sz,
                          input int stall);
    for (int c = 0; c <= stall; c++) begin
      m_arready = (c == stall);
      #1;
      chk("ar_valid", m_arvalid, 1'b1);
      chk("ar_addr", m_araddr, a);
      chk("ar_len", m_arlen, len);
      chk("ar_size", m_arsize, sz);
      chk("ar_burst", m_arburst, 2'b01);
      chk("ar_id", m_arid, r ? 4'h1 : 4'h0);
      chk("ar_no_sready", s_arready, 2'b00);
      tick();
    end
    m_arready = 1'b0;
  endtask

  task automatic r_phase(input int r, input int n, input logic [63:0] d0,
                         input int bp_beat, input int bp_cyc);
    for (int b = 0; b < n; b++) begin
      beat_t e;
      m_rvalid = 1'b1;
      m_rdata  = d0 + 64'(b);
      m_rresp  = 2'(b);
      m_rlast  = (b == n - 1);
      e.who = r[0]; e.data = m_rdata; e.resp = m_rresp; e.last = m_rlast;
      sb.push_back(e);
      if (b == bp_beat) begin
        s_rready[r] = 1'b0;
        for (int c = 0; c < bp_cyc; c++) begin
          #1;
          chk("bp_mrready", m_rready, 1'b0);
          chk("bp_srvalid", s_rvalid, 2'b01 << r);
          tick();
        end
        s_rready[r] = 1'b1;
      end
      #1;
      chk("r_mrready", m_rready, 1'b1);
      chk("r_no_sready", s_arready, 2'b00);
      tick();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0; m_rresp = '0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    #1;
    chk({tag, "_arvalid"}, m_arvalid, 1'b0);
    chk({tag, "_srvalid"}, s_rvalid, 2'b00);
    chk({tag, "_mrready"}, m_rready, 1'b0);
  endtask

  initial begin
    int w;
    reset = 1'b1;
    s_arvalid = '0; s_araddr = '0; s_arlen = '0;
    s_arsize = '0; s_arburst = '0; s_rready = 2'b11;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rid = '0;
    m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
    tick(); tick();
    chk("rst_sarready", s_arready, 2'b00);
    chk("rst_arvalid", m_arvalid, 1'b0);
    chk("rst_srvalid", s_rvalid, 2'b00);
    chk("rst_mrready", m_rready, 1'b0);
    chk("rst_araddr", m_araddr, 32'h0);
    chk("rst_arlen", m_arlen, 8'h0);
    chk("rst_arid", m_arid, 4'h0);
    reset = 1'b0;
    tick();

    // ICache single beat
    req(0, 32'h8000_0000, 8'd0, 3'd3);
    wait_accept(0, w);
    ar_phase(0, 32'h8000_0000, 8'd0, 3'd3, 0);
    r_phase(0, 1, 64'h1122334455667788, -1, 0);
    chk_idle_outputs("t1_idle");
    tick();

    // DCache two beats
    req(1, 32'h8000_1000, 8'd1, 3'd3);
    wait_accept(1, w);
    ar_phase(1, 32'h8000_1000, 8'd1, 3'd3, 0);
    r_phase(1, 2, 64'hAAAA_0000_0000_0010, -1, 0);
    chk_idle_outputs("t2_idle");
    tick();

    // Round robin from reset
    reset = 1'b1; tick(); reset = 1'b0;
    req(0, 32'h8000_0100, 8'd0, 3'd2);
    req(1, 32'h8000_0200, 8'd0, 3'd2);
    wait_accept(0, w);
    chk("rr_first_wait", w, 0);
    ar_phase(0, 32'h8000_0100, 8'd0, 3'd2, 0);
    r_phase(0, 1, 64'h0101, -1, 0);
    wait_accept(1, w);
    chk("rr_gap_wait", w, 0);
    ar_phase(1, 32'h8000_0200, 8'd0, 3'd2, 0);
    r_phase(1, 1, 64'h0202, -1, 0);
    req(0, 32'h8000_0300, 8'd0, 3'd2);
    req(1, 32'h8000_0400, 8'd0, 3'd2);
    wait_accept(0, w);
    ar_phase(0, 32'h8000_0300, 8'd0, 3'd2, 0);
    r_phase(0, 1, 64'h0303, -1, 0);
    wait_accept(1, w);
    ar_phase(1, 32'h8000_0400, 8'd0, 3'd2, 0);
    r_phase(1, 1, 64'h0404, -1, 0);
    tick();

    // AR stall, ICache waits meanwhile
    req(1, 32'h8000_2000, 8'd0, 3'd3);
    wait_accept(1, w);
    req(0, 32'h8000_3000, 8'd0, 3'd3);
    ar_phase(1, 32'h8000_2000, 8'd0, 3'd3, 3);
    r_phase(1, 1, 64'h5555, -1, 0);
    wait_accept(0, w);
    chk("stall_next_wait", w, 0);
    ar_phase(0, 32'h8000_3000, 8'd0, 3'd3, 0);
    r_phase(0, 1, 64'h6666, -1, 0);
    tick();

    // R backpressure
    req(1, 32'h8000_4000, 8'd2, 3'd3);
    wait_accept(1, w);
    ar_phase(1, 32'h8000_4000, 8'd2, 3'd3, 0);
    r_phase(1, 3, 64'h7000, 1, 2);
    chk_idle_outputs("t5_idle");
    tick();

    // Reset during beat 2
    req(0, 32'h8000_5000, 8'd3, 3'd3);
    wait_accept(0, w);
    ar_phase(0, 32'h8000_5000, 8'd3, 3'd3, 0);
    begin
      beat_t e;
      m_rvalid = 1'b1; m_rdata = 64'h9000; m_rresp = 2'b00; m_rlast = 1'b0;
      e.who = 1'b0; e.data = 64'h9000; e.resp = 2'b00; e.last = 1'b0;
      sb.push_back(e);
      #1;
      chk("rst_b1_mrready", m_rready, 1'b1);
      tick();
    end
    m_rdata = 64'h9001;
    s_rready[0] = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_b2_mrready", m_rready, 1'b0);
    tick();
    m_rvalid = 1'b0; m_rdata = '0; s_rready = 2'b11;
    #1;
    chk("mid_rst_sarready", s_arready, 2'b00);
    chk("mid_rst_arvalid", m_arvalid, 1'b0);
    chk("mid_rst_srvalid", s_rvalid, 2'b00);
    chk("mid_rst_mrready", m_rready, 1'b0);
    chk("mid_rst_araddr", m_araddr, 32'h0);
    chk("mid_rst_arlen", m_arlen, 8'h0);
    chk("mid_rst_sdata", s_rdata, 64'h0);
    reset = 1'b0;
    tick();
    req(1, 32'h8000_6000, 8'd0, 3'd3);
    wait_accept(1, w);
    chk("post_rst_wait", w, 0);
    ar_phase(1, 32'h8000_6000, 8'd0, 3'd3, 0);
    r_phase(1, 1, 64'hABCD, -1, 0);
    chk_idle_outputs("t6_idle");
    tick();

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
